// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counting timer at 0x180-0x183.
//   0x180 CTRL   (bit0 en, bit1 reload, bit2 irq_en)
//   0x181 PERIOD (reload value)
//   0x182 COUNT  (current count, decrements while running)
//   0x183 STATUS (bit0 flag, write-1-to-clear)
// Optional feature: define TIMER_IRQ_EN to add the irq output and make
// CTRL.irq_en writable; without it CTRL bit2 reads 0 and irq is absent.
module mmio_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        expired
`ifdef TIMER_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [2:0] MREAD     = 3'b010;
  localparam logic [2:0] MWRITE    = 3'b100;
  localparam logic [6:0] BASE_PAGE = 7'b1100000;
  localparam logic [1:0] A_CTRL    = 2'd0;
  localparam logic [1:0] A_PERIOD  = 2'd1;
  localparam logic [1:0] A_COUNT   = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

`ifdef TIMER_IRQ_EN
  localparam logic IRQ_IMPL = 1'b1;
`else
  localparam logic IRQ_IMPL = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_reload;
  logic        r_irq_en;
  logic [15:0] r_period;
  logic [15:0] r_count;
  logic        r_flag;

  logic        w_sel;
  logic        w_rd;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_period;
  logic        w_wr_count;
  logic        w_wr_status;
  logic        w_run;
  logic        w_expire;
  logic [15:0] w_rdata;

  // Any command other than an exact MREAD/MWRITE encoding is treated as no-op.
  assign w_sel       = (mem_addr[8:2] == BASE_PAGE);
  assign w_rd        = w_sel && (mem_cmd == MREAD);
  assign w_wr        = w_sel && (mem_cmd == MWRITE);
  assign w_wr_ctrl   = w_wr && (mem_addr[1:0] == A_CTRL);
  assign w_wr_period = w_wr && (mem_addr[1:0] == A_PERIOD);
  assign w_wr_count  = w_wr && (mem_addr[1:0] == A_COUNT);
  assign w_wr_status = w_wr && (mem_addr[1:0] == A_STATUS);

  // CTRL.en is not stored separately: it is exactly "state is RUN".
  assign w_run    = (r_state == ST_RUN);
  assign w_expire = w_run && (r_count == 16'd0);

  // Read mux over the current register values; unused bits are zero.
  always_comb begin
    w_rdata = 16'h0000;
    case (mem_addr[1:0])
      A_CTRL:   w_rdata = {13'h0000, r_irq_en, r_reload, w_run};
      A_PERIOD: w_rdata = r_period;
      A_COUNT:  w_rdata = r_count;
      A_STATUS: w_rdata = {15'h0000, r_flag};
      default:  w_rdata = 16'h0000;
    endcase
  end

  // Shared read bus: drive only for a selected read, float otherwise.
  assign dout = w_rd ? w_rdata : 16'bzzzz_zzzz_zzzz_zzzz;

  // Timer FSM and register file; later assignments in this block take
  // priority, giving the order: expiry/decrement, then CPU writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_reload <= 1'b0;
      r_irq_en <= 1'b0;
      r_period <= 16'h0000;
      r_count  <= 16'h0000;
      r_flag   <= 1'b0;
    end else begin
      // Counting and expiry actions.
      case (r_state)
        ST_RUN: begin
          if (r_count == 16'd0) begin
            r_flag <= 1'b1;
            if (r_reload) begin
              r_count <= r_period;
            end else begin
              r_state <= ST_DONE;
            end
          end else begin
            r_count <= r_count - 16'd1;
          end
        end
        ST_IDLE, ST_DONE: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // STATUS write-1-to-clear; a simultaneous expiry keeps the flag set.
      if (w_wr_status && din[0] && !w_expire) begin
        r_flag <= 1'b0;
      end

      // CTRL write lands after the expiry actions, so en takes din[0].
      if (w_wr_ctrl) begin
        r_reload <= din[1];
        r_irq_en <= din[2] & IRQ_IMPL;
        if (din[0]) begin
          r_state <= ST_RUN;
        end else if (w_run) begin
          if (!w_expire) begin
            // Stopping a running timer freezes COUNT (no decrement this cycle).
            r_state <= ST_IDLE;
            r_count <= r_count;
          end else if (r_reload) begin
            r_state <= ST_IDLE;
          end
        end
      end

      if (w_wr_period) begin
        r_period <= din;
      end

      // A CPU COUNT write overrides any decrement or reload this cycle.
      if (w_wr_count) begin
        r_count <= din;
      end
    end
  end

  assign expired = r_flag;

`ifdef TIMER_IRQ_EN
  assign irq = r_flag & r_irq_en;
`endif

endmodule

// File: tb/tb_mmio_timer.sv
// Testbench for mmio_timer: directed scenarios plus randomized bus traffic,
// checked by a scoreboard against a behavioural model of the register map.
module tb_mmio_timer;

  localparam logic [2:0] MNONE  = 3'b001;
  localparam logic [2:0] MREAD  = 3'b010;
  localparam logic [2:0] MWRITE = 3'b100;

`ifdef TIMER_IRQ_EN
  localparam logic HAS_IRQ = 1'b1;
`else
  localparam logic HAS_IRQ = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [2:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] din;
  wire  [15:0] dout;
  logic        expired;
`ifdef TIMER_IRQ_EN
  logic        irq;
`endif

  mmio_timer dut (
    .clk      (clk),
    .reset    (reset),
    .mem_cmd  (mem_cmd),
    .mem_addr (mem_addr),
    .din      (din),
    .dout     (dout),
    .expired  (expired)
`ifdef TIMER_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = no check, 1 = model expectation, 2 = directed constant for dout
  typedef struct {
    int          kind;
    logic        drive;
    logic [15:0] dout;
    logic        expired;
    logic        irq;
    logic [8:0]  addr;
  } rec_t;

  rec_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model of the timer as seen from the bus.
  logic        m_run;
  logic        m_reload;
  logic        m_irqen;
  logic [15:0] m_period;
  logic [15:0] m_count;
  logic        m_flag;

  function automatic logic in_window(input logic [8:0] a);
    return (a >= 9'h180) && (a <= 9'h183);
  endfunction

  function automatic logic [15:0] model_read(input logic [8:0] a);
    logic [1:0] off;
    off = a[1:0];
    if (off == 2'd0) return {13'h0000, m_irqen, m_reload, m_run};
    if (off == 2'd1) return m_period;
    if (off == 2'd2) return m_count;
    return {15'h0000, m_flag};
  endfunction

  task automatic model_step(input logic r, input logic [2:0] c,
                            input logic [8:0] a, input logic [15:0] d);
    logic        wr;
    logic        fire;
    logic        n_run, n_reload, n_irqen, n_flag;
    logic [15:0] n_count, n_period;
    if (r) begin
      m_run = 1'b0; m_reload = 1'b0; m_irqen = 1'b0;
      m_period = 16'h0000; m_count = 16'h0000; m_flag = 1'b0;
    end else begin
      wr       = (c == MWRITE) && in_window(a);
      fire     = m_run && (m_count == 16'h0000);
      n_run    = m_run;
      n_reload = m_reload;
      n_irqen  = m_irqen;
      n_period = m_period;
      n_count  = m_count;
      n_flag   = m_flag;
      // Running timer: count down, or on reaching zero raise the flag and
      // either reload from PERIOD or stop.
      if (fire) begin
        n_flag = 1'b1;
        if (m_reload) n_count = m_period;
        else n_run = 1'b0;
      end else if (m_run) begin
        n_count = m_count - 16'h0001;
      end
      if (wr && a == 9'h183 && d[0] && !fire) n_flag = 1'b0;
      if (wr && a == 9'h180) begin
        n_run    = d[0];
        n_reload = d[1];
        n_irqen  = d[2] & HAS_IRQ;
        if (m_run && !d[0] && !fire) n_count = m_count;
      end
      if (wr && a == 9'h181) n_period = d;
      if (wr && a == 9'h182) n_count = d;
      m_run = n_run; m_reload = n_reload; m_irqen = n_irqen;
      m_period = n_period; m_count = n_count; m_flag = n_flag;
    end
  endtask

  // One bus cycle: drive inputs, queue what the DUT must show during this
  // cycle, then advance the model across the coming clock edge.
  task automatic cyc(input logic r, input logic [2:0] c, input logic [8:0] a,
                     input logic [15:0] d, input int kind, input logic [15:0] dexp);
    rec_t e;
    reset    = r;
    mem_cmd  = c;
    mem_addr = a;
    din      = d;
    e.kind    = kind;
    e.drive   = (c == MREAD) && in_window(a);
    e.dout    = (kind == 2) ? dexp : model_read(a);
    e.expired = m_flag;
    e.irq     = m_flag & m_irqen;
    e.addr    = a;
    sb_q.push_back(e);
    model_step(r, c, a, d);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    cyc(1'b0, MWRITE, a, d, 1, 16'h0000);
  endtask

  task automatic rd(input logic [8:0] a);
    cyc(1'b0, MREAD, a, 16'h0000, 1, 16'h0000);
  endtask

  task automatic rdx(input logic [8:0] a, input logic [15:0] v);
    cyc(1'b0, MREAD, a, 16'h0000, 2, v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, MNONE, 9'h000, 16'h0000, 1, 16'h0000);
  endtask

  // Monitor: pop one expectation per cycle and compare mid-cycle.
  rec_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      if (mon_e.kind != 0) begin
        checks++;
        if (expired !== mon_e.expired) begin
          errors++;
          $display("FAIL expired addr=%h: got %b expected %b", mon_e.addr, expired, mon_e.expired);
        end
`ifdef TIMER_IRQ_EN
        checks++;
        if (irq !== mon_e.irq) begin
          errors++;
          $display("FAIL irq addr=%h: got %b expected %b", mon_e.addr, irq, mon_e.irq);
        end
`endif
        checks++;
        if (mon_e.drive) begin
          if (dout !== mon_e.dout) begin
            errors++;
            $display("FAIL read addr=%h: got %h expected %h", mon_e.addr, dout, mon_e.dout);
          end
        end else begin
          // Undriven bus: z in a 4-state simulator, 0 where z resolves to 0.
          if (!($isunknown(dout) || dout == 16'h0000)) begin
            errors++;
            $display("FAIL float addr=%h: got %h expected z", mon_e.addr, dout);
          end
        end
      end
    end
  end

  initial begin
    logic [2:0]  c;
    logic [8:0]  a;
    logic [15:0] d;
    logic        r;
    int          p;
    int          guard;

    reset = 1'b1; mem_cmd = MNONE; mem_addr = 9'h000; din = 16'h0000;
    m_run = 1'b0; m_reload = 1'b0; m_irqen = 1'b0;
    m_period = 16'h0000; m_count = 16'h0000; m_flag = 1'b0;
    @(posedge clk);
    #1;

    // Reset, then every register reads zero; outside the window nothing drives.
    cyc(1'b1, MNONE, 9'h000, 16'h0000, 0, 16'h0000);
    rdx(9'h180, 16'h0000);
    rdx(9'h181, 16'h0000);
    rdx(9'h182, 16'h0000);
    rdx(9'h183, 16'h0000);
    rd(9'h140);

    // One-shot: load 3 counts down 3,2,1,0 then stops with the flag set.
    wr(9'h181, 16'd5);
    wr(9'h182, 16'd3);
    wr(9'h180, 16'h0001);
    rdx(9'h182, 16'd3);
    rdx(9'h182, 16'd2);
    rdx(9'h182, 16'd1);
    rdx(9'h182, 16'd0);
    rdx(9'h183, 16'h0001);
    rdx(9'h180, 16'h0000);
    rdx(9'h182, 16'd0);

    // Auto-reload: expiry reloads PERIOD=5, next expiry 6 cycles later,
    // and a W1C between expiries clears the flag.
    wr(9'h183, 16'h0001);
    wr(9'h182, 16'd2);
    wr(9'h180, 16'h0003);
    rdx(9'h182, 16'd2);
    rdx(9'h182, 16'd1);
    rdx(9'h182, 16'd0);
    rdx(9'h183, 16'h0001);
    wr(9'h183, 16'h0001);
    rdx(9'h183, 16'h0000);
    rdx(9'h183, 16'h0000);
    rdx(9'h183, 16'h0000);
    rdx(9'h183, 16'h0000);
    rdx(9'h183, 16'h0001);
    rdx(9'h182, 16'd4);

    // W1C in the expiry cycle loses; a COUNT write while running wins and
    // the count continues down from the written value.
    wr(9'h180, 16'h0000);
    wr(9'h183, 16'h0001);
    wr(9'h182, 16'd1);
    wr(9'h180, 16'h0003);
    idle(1);
    wr(9'h183, 16'h0001);
    rdx(9'h183, 16'h0001);
    wr(9'h182, 16'h0010);
    rdx(9'h182, 16'h0010);
    rdx(9'h182, 16'h000F);

    // Illegal command encodings act as no-ops and leave the bus floating.
    wr(9'h180, 16'h0000);
    cyc(1'b0, 3'b110, 9'h181, 16'h1234, 1, 16'h0000);
    cyc(1'b0, 3'b000, 9'h181, 16'h4321, 1, 16'h0000);
    cyc(1'b0, 3'b111, 9'h181, 16'hBEEF, 1, 16'h0000);
    rdx(9'h181, 16'd5);

    // PERIOD=0 with reload: flag re-asserts every cycle despite W1C.
    wr(9'h181, 16'd0);
    wr(9'h182, 16'd0);
    wr(9'h180, 16'h0003);
    idle(1);
    wr(9'h183, 16'h0001);
    wr(9'h183, 16'h0001);
    rdx(9'h183, 16'h0001);
    wr(9'h180, 16'h0000);
    wr(9'h183, 16'h0001);
    rdx(9'h183, 16'h0000);

    // Reset in the middle of a run clears everything.
    wr(9'h181, 16'd7);
    wr(9'h182, 16'd9);
    wr(9'h180, 16'h0003);
    idle(3);
    cyc(1'b1, MWRITE, 9'h182, 16'h5555, 1, 16'h0000);
    rdx(9'h180, 16'h0000);
    rdx(9'h181, 16'h0000);
    rdx(9'h182, 16'h0000);
    rdx(9'h183, 16'h0000);

    // irq_en path: CTRL=0x5 with COUNT=0 expires at once; bit2 only exists
    // in the irq build. Clearing CTRL drops irq.
    wr(9'h182, 16'd0);
    wr(9'h180, 16'h0005);
    rdx(9'h180, HAS_IRQ ? 16'h0005 : 16'h0001);
    rdx(9'h180, HAS_IRQ ? 16'h0004 : 16'h0000);
    wr(9'h180, 16'h0000);
    idle(2);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      p = $urandom_range(0, 99);
      r = (p < 2);
      p = $urandom_range(0, 99);
      if (p < 30) c = MREAD;
      else if (p < 65) c = MWRITE;
      else if (p < 80) c = MNONE;
      else begin
        d = 16'($urandom_range(0, 3));
        c = (d[1:0] == 2'd0) ? 3'b000 : (d[1:0] == 2'd1) ? 3'b110 :
            (d[1:0] == 2'd2) ? 3'b111 : 3'b011;
      end
      if ($urandom_range(0, 99) < 85) a = 9'h180 | 9'($urandom_range(0, 3));
      else a = 9'($urandom_range(0, 511));
      if ((a == 9'h181 || a == 9'h182) && $urandom_range(0, 9) != 0)
        d = 16'($urandom_range(0, 12));
      else
        d = 16'($urandom());
      cyc(r, c, a, d, 1, 16'h0000);
    end

    cyc(1'b0, MNONE, 9'h000, 16'h0000, 0, 16'h0000);
    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
